// File: rtl/i2c_slave_single_byte.sv
// Fixed-address I2C target: receives written bytes, serves read bytes from user logic.
// SCL is only observed (no clock stretching); SDA is open-drain.
`timescale 1ns/1ps
module i2c_slave_single_byte #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  output logic       o_busy,
  output logic       o_nack,
  inout  wire        io_scl,
  inout  wire        io_sda
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] shift_in_s;

  state_t     state_r;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       rw_r;
  logic       phase_r;
  logic       sda_oe_r;
  logic       busy_r;
  logic [7:0] rx_byte_r;
  logic       rx_valid_r;
  logic       tx_req_r;
  logic       nack_r;

  // Synchronize the bus pins and keep the previous value for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], io_scl};
      sda_sync_r <= {sda_sync_r[0], io_sda};
      scl_prev_r <= scl_sync_r[1];
      sda_prev_r <= sda_sync_r[1];
    end
  end

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign shift_in_s = {shift_r[6:0], sda_s};

  // Protocol FSM; phase_r marks the second half of an ACK slot (or a received ACK in TX_ACK).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      rw_r       <= 1'b0;
      phase_r    <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      nack_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      nack_r     <= 1'b0;
      if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 3'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b0;
        phase_r   <= 1'b0;
      end else if (stop_s) begin
        state_r  <= ST_IDLE;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
        phase_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= shift_in_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                if (shift_in_s[7:1] == SLAVE_ADDR) begin
                  state_r <= ST_ADDR_ACK;
                  rw_r    <= shift_in_s[0];
                  phase_r <= 1'b0;
                end else begin
                  state_r <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                sda_oe_r <= 1'b1;
                busy_r   <= 1'b1;
                phase_r  <= 1'b1;
              end else begin
                phase_r   <= 1'b0;
                bit_cnt_r <= 3'd0;
                if (rw_r) begin
                  shift_r  <= i_tx_byte;
                  tx_req_r <= 1'b1;
                  sda_oe_r <= ~i_tx_byte[7];
                  state_r  <= ST_TX;
                end else begin
                  sda_oe_r <= 1'b0;
                  state_r  <= ST_RX;
                end
              end
            end
          end
          ST_RX: begin
            if (scl_rise_s) begin
              shift_r   <= shift_in_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rx_byte_r  <= shift_in_s;
                rx_valid_r <= 1'b1;
                phase_r    <= 1'b0;
                state_r    <= ST_RX_ACK;
              end
            end
          end
          ST_RX_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                sda_oe_r <= 1'b1;
                phase_r  <= 1'b1;
              end else begin
                sda_oe_r <= 1'b0;
                phase_r  <= 1'b0;
                state_r  <= ST_RX;
              end
            end
          end
          ST_TX: begin
            // Bit 7 is already on the bus; each fall moves to the next bit.
            if (scl_fall_s) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                sda_oe_r <= 1'b0;
                phase_r  <= 1'b0;
                state_r  <= ST_TX_ACK;
              end else begin
                sda_oe_r <= ~shift_r[6];
                shift_r  <= {shift_r[6:0], 1'b0};
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise_s) begin
              if (!sda_s) begin
                phase_r <= 1'b1;
              end else begin
                nack_r   <= 1'b1;
                sda_oe_r <= 1'b0;
                state_r  <= ST_WAIT_STOP;
              end
            end else if (scl_fall_s && phase_r) begin
              phase_r   <= 1'b0;
              bit_cnt_r <= 3'd0;
              shift_r   <= i_tx_byte;
              tx_req_r  <= 1'b1;
              sda_oe_r  <= ~i_tx_byte[7];
              state_r   <= ST_TX;
            end
          end
          ST_IDLE, ST_WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_sda     = sda_oe_r ? 1'b0 : 1'bz;
  assign o_rx_byte  = rx_byte_r;
  assign o_rx_valid = rx_valid_r;
  assign o_tx_req   = tx_req_r;
  assign o_busy     = busy_r;
  assign o_nack     = nack_r;

endmodule

// File: doc/i2c_slave_single_byte.md
# i2c_slave_single_byte

I2C target (responder) that answers a master on the shared SCL/SDA bus at one fixed 7-bit address. It is the bus-side counterpart of the single-byte master wrapper and is used for on-board register endpoints and for loopback verification of the master. Master writes produce one received byte per data phase. Master reads are served from a byte the user logic provides. Clock stretching is not supported.

## Interface
- SLAVE_ADDR, 7'h42, 7-bit address this target answers to
- i_clk  input  1  system clock; must be at least 16x the SCL frequency
- i_rst_n  input  1  asynchronous active-low reset
- i_tx_byte  input  8  byte returned on a master read; sampled at o_tx_req
- o_rx_byte  output  8  last byte written by the master
- o_rx_valid  output  1  one-cycle pulse: o_rx_byte is updated
- o_tx_req  output  1  one-cycle pulse: i_tx_byte latched into the shifter this cycle
- o_busy  output  1  high while addressed (from address ACK until STOP/START)
- o_nack  output  1  one-cycle pulse: master NACKed a read byte
- io_scl  inout  1  I2C clock; only sampled, never driven
- io_sda  inout  1  I2C data; open-drain, io_sda = sda_oe ? 1'b0 : 1'bZ

## Operation
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer. A third register holds the previous synchronized value, which gives edge detection.
- Bus events, evaluated on synchronized values:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - scl_rise / scl_fall: the corresponding SCL edge.
- Data is sampled on scl_rise. sda_oe changes only on scl_fall, never while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- START from any state, including a repeated START:
  - Go to ADDR.
  - Clear the bit counter.
  - Release SDA and drop o_busy.
- STOP from any state goes to IDLE, releases SDA and drops o_busy.
- ADDR:
  - Shift 8 bits MSB-first on scl_rise.
  - After bit 8, compare shifter[7:1] with SLAVE_ADDR.
  - On a match, go to ADDR_ACK and latch R/W = shifter[0]. On a mismatch, go to WAIT_STOP.
- ADDR_ACK:
  - On the next scl_fall, assert sda_oe and o_busy.
  - On the following scl_fall, release SDA.
  - If R/W=0, go to RX.
  - If R/W=1, load i_tx_byte, pulse o_tx_req, go to TX, and drive bit 7 in the same cycle (sda_oe = ~bit).
- RX:
  - Shift 8 bits on scl_rise.
  - After bit 8: update o_rx_byte, pulse o_rx_valid, go to RX_ACK.
- RX_ACK:
  - Drive ACK low from the next scl_fall to the one after it.
  - Return to RX. A master may write any number of bytes, and each one pulses o_rx_valid.
- TX:
  - On each scl_fall, present the next bit. On the 8th scl_fall, release SDA.
  - Go to TX_ACK.
- TX_ACK:
  - Sample SDA on scl_rise.
  - Low (ACK): on the next scl_fall, reload i_tx_byte, pulse o_tx_req, drive bit 7, and go to TX.
  - High (NACK): pulse o_nack, release SDA, go to WAIT_STOP.
- WAIT_STOP: ignore everything until STOP or START.
- Counters: a 3-bit bit counter wraps from 7 to 0. The 8th bit is detected at count 7 on scl_rise.

## Timing
- Reset values:
  - State is IDLE and sda_oe=0, so SDA is released.
  - o_busy=0, o_rx_valid=0, o_tx_req=0, o_nack=0.
  - o_rx_byte=8'h00; the shifter and bit counter are 0.
- Event latency: a START, STOP or edge takes effect 3 i_clk cycles after the pin transition (2 synchronizer stages plus the edge register).
- Drive latency: sda_oe changes 1 cycle after the detected scl_fall. This gives about 4 i_clk cycles of hold after the real SCL fall.
- o_rx_valid is asserted in the cycle after the scl_rise of data bit 0, for exactly 1 cycle.
- o_tx_req: i_tx_byte must be stable in the cycle o_tx_req is high. Between bytes, user logic has the ACK-bit SCL-low time to update it.
- START and STOP have priority over a data edge seen in the same cycle.
- Reset mid-transfer releases SDA immediately and asynchronously. The block then waits in IDLE for the next START.
- o_busy drops in the cycle after STOP or START is detected.

## Test plan
- Write at address 0x42 with data 0xA5:
  - ACK is low on the address 9th clock and on the data 9th clock.
  - o_rx_byte=0xA5 with one o_rx_valid pulse.
  - o_busy is high from the address ACK until STOP.
- Address 0x43 write:
  - SDA is never driven low.
  - No o_rx_valid and o_busy stays 0.
  - The next START at 0x42 is answered normally.
- Read with i_tx_byte=0x3C, master ACKs, then i_tx_byte=0xC3 and master NACKs:
  - Bus carries 0x3C then 0xC3.
  - Two o_tx_req pulses and one o_nack pulse.
  - SDA is released after the NACK.
- Write 0x11 with no STOP, then repeated START read at 0x42:
  - o_rx_byte=0x11.
  - The read returns i_tx_byte with no STOP in between.
- i_rst_n low while TX is driving a 0 bit:
  - SDA is released within the same cycle.
  - All outputs go to their reset values.
  - The next transaction works.
- Master writes 3 bytes 0x01, 0x02, 0x03:
  - Three o_rx_valid pulses, in that order.
  - Each byte is ACKed.
  - SDA and sda_oe never change while SCL is high.
